// File: rtl/audio_src_arbiter_if.sv
// audio_src_arbiter_if: source/sink handshake bundle for audio_src_arbiter
//   master: arbiter side (drives readys, sink register, grant status)
//   slave : environment side (sources, enables, sink back-pressure)
interface audio_src_arbiter_if #(parameter int WIDTH = 24);
  logic [1:0]         src_enable;
  logic [2*WIDTH-1:0] src0_data;
  logic               src0_valid;
  logic               src0_ready;
  logic [2*WIDTH-1:0] src1_data;
  logic               src1_valid;
  logic               src1_ready;
  logic [2*WIDTH-1:0] sink_data;
  logic               sink_valid;
  logic               sink_full;
  logic               grant_valid;
  logic               active_src;
  logic               burst_done;
  logic [15:0]        timeout_count;
  modport master (
    input  src_enable, src0_data, src0_valid, src1_data, src1_valid, sink_full,
    output src0_ready, src1_ready, sink_data, sink_valid, grant_valid, active_src,
           burst_done, timeout_count
  );
  modport slave (
    output src_enable, src0_data, src0_valid, src1_data, src1_valid, sink_full,
    input  src0_ready, src1_ready, sink_data, sink_valid, grant_valid, active_src,
           burst_done, timeout_count
  );
endinterface

// File: rtl/audio_src_arbiter.sv
// audio_src_arbiter: round-robin burst arbiter sharing one stereo sink between two sources
//   clk, reset (async, active-high); bus (audio_src_arbiter_if.master):
//   src_enable, srcN_data/valid/ready, sink_data/valid/full, grant_valid,
//   active_src, burst_done, timeout_count.
//   Define AUDIO_ARB_SILENCE_FILL_EN to stream zero samples while IDLE.
module audio_src_arbiter #(
  parameter int WIDTH        = 24,
  parameter int BURST_LEN    = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  audio_src_arbiter_if.master bus
);
`ifdef AUDIO_ARB_SILENCE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, state_nx;
  logic last, cur, cur_valid, cur_en, can_load, stall, xfer, burst_end, timeout, grant_end, fill;
  logic [2*WIDTH-1:0] cur_data;
  logic [15:0] burst_cnt, idle_cnt;
  assign cur = state == GRANT1;
  assign can_load = !bus.sink_valid || !bus.sink_full;
  assign stall = bus.sink_valid && bus.sink_full;
  assign bus.src0_ready = state == GRANT0 && bus.src_enable[0] && can_load;
  assign bus.src1_ready = state == GRANT1 && bus.src_enable[1] && can_load;
  assign bus.grant_valid = state != IDLE;
  assign cur_valid = cur ? bus.src1_valid : bus.src0_valid;
  assign cur_data = cur ? bus.src1_data : bus.src0_data;
  assign cur_en = bus.src_enable[cur];
  assign xfer = (bus.src0_valid && bus.src0_ready) || (bus.src1_valid && bus.src1_ready);
  assign burst_end = xfer && burst_cnt == 16'(BURST_LEN - 1);
  // idle cycles only count while the sink is not holding us back
  assign timeout = state != IDLE && !cur_valid && !stall && idle_cnt == 16'(IDLE_TIMEOUT - 1);
  assign grant_end = state != IDLE && (burst_end || timeout || !cur_en);
  assign fill = FILL && state == IDLE && can_load;
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = bus.src_enable == 2'b11 ? (last ? GRANT0 : GRANT1) :
                 bus.src_enable[0] ? GRANT0 : bus.src_enable[1] ? GRANT1 : IDLE;
    else if (grant_end)
      state_nx = bus.src_enable[~cur] ? (cur ? GRANT0 : GRANT1) : cur_en ? state : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      bus.active_src <= 1'b0;
      burst_cnt <= '0;
      idle_cnt <= '0;
      bus.sink_data <= '0;
      bus.sink_valid <= 1'b0;
      bus.burst_done <= 1'b0;
      bus.timeout_count <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != IDLE) bus.active_src <= state_nx == GRANT1;
      if (grant_end) last <= cur;
      bus.burst_done <= burst_end;
      if (timeout && bus.timeout_count != 16'hFFFF) bus.timeout_count <= bus.timeout_count + 16'd1;
      burst_cnt <= state == IDLE || grant_end ? '0 : xfer ? burst_cnt + 16'd1 : burst_cnt;
      idle_cnt <= state == IDLE || grant_end || xfer ? '0 :
                  !cur_valid && !stall ? idle_cnt + 16'd1 : idle_cnt;
      // a source load always wins; otherwise a drained register goes empty
      if (xfer || fill) begin
        bus.sink_data <= xfer ? cur_data : '0;
        bus.sink_valid <= 1'b1;
      end else if (!bus.sink_full) bus.sink_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_audio_src_arbiter.sv
// tb_audio_src_arbiter: directed scoreboard bench for audio_src_arbiter (BURST_LEN=4, IDLE_TIMEOUT=16)
module tb_audio_src_arbiter;
`ifdef AUDIO_ARB_SILENCE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  logic x0, x1;
  logic [47:0] d0, d1, held;
  logic [47:0] q[$];
  audio_src_arbiter_if #(.WIDTH(24)) bus ();
  audio_src_arbiter #(.WIDTH(24), .BURST_LEN(4), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  // observe handshakes just before the edge, then advance to 1 time unit past it
  task automatic step();
    #2;
    x0 = bus.src0_valid && bus.src0_ready;
    x1 = bus.src1_valid && bus.src1_ready;
    if (bus.sink_valid && !bus.sink_full) begin
      if (q.size() != 0) check("sink_data", bus.sink_data, q.pop_front());
      else if (FILL) check("silence_data", bus.sink_data, 48'd0);
      else check1("spurious_sink", bus.sink_valid, 1'b0);
    end
    if (x0) q.push_back(d0);
    if (x1) q.push_back(d1);
    @(posedge clk);
    #1;
    if (x0) d0++;
    if (x1) d1++;
    bus.src0_data = d0;
    bus.src1_data = d1;
  endtask
  task automatic drain();
    bus.src_enable = 2'b00;
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
    bus.sink_full = 1'b0;
    repeat (3) step();
    check("drain_queue", 48'(q.size()), 48'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("idle_grant", bus.grant_valid, 1'b0);
      check1("idle_sink_valid", bus.sink_valid, FILL);
      if (FILL) check("idle_sink_data", bus.sink_data, 48'd0);
    end
  endtask
  initial begin
    reset = 1'b1;
    d0 = 48'd0;
    d1 = 48'h000001_000000;
    bus.src_enable = 2'b00;
    bus.src0_data = d0;
    bus.src0_valid = 1'b0;
    bus.src1_data = d1;
    bus.src1_valid = 1'b0;
    bus.sink_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sink_data", bus.sink_data, 48'd0);
    check1("rst_sink_valid", bus.sink_valid, 1'b0);
    check1("rst_ready0", bus.src0_ready, 1'b0);
    check1("rst_ready1", bus.src1_ready, 1'b0);
    check1("rst_grant", bus.grant_valid, 1'b0);
    check1("rst_active", bus.active_src, 1'b0);
    check1("rst_burst_done", bus.burst_done, 1'b0);
    check("rst_timeouts", 48'(bus.timeout_count), 48'd0);
    reset = 1'b0;
    // round-robin: last=1 after reset, so src0 goes first
    bus.src_enable = 2'b11;
    bus.src0_valid = 1'b1;
    bus.src1_valid = 1'b1;
    step();
    check1("rr_idle_no_xfer", x0 | x1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step();
      check1("rr_src0", x0, (k / 4) % 2 == 0);
      check1("rr_src1", x1, (k / 4) % 2 == 1);
      check1("rr_burst_done", bus.burst_done, k % 4 == 3);
      check1("rr_active", bus.active_src, ((k + 1) / 4) % 2 == 1);
      check1("rr_sink_valid", bus.sink_valid, 1'b1);
    end
    drain();
    // single source, incrementing pattern from 0
    d0 = 48'd0;
    bus.src0_data = d0;
    bus.src_enable = 2'b01;
    bus.src0_valid = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      step();
      check1("single_xfer", x0, 1'b1);
      check1("single_burst_done", bus.burst_done, k % 4 == 3);
      check1("single_active", bus.active_src, 1'b0);
      check1("single_sink_valid", bus.sink_valid, 1'b1);
    end
    drain();
    // back-pressure with src0 idle: the held sample stays and idle_cnt must not run
    bus.src_enable = 2'b01;
    bus.src0_valid = 1'b1;
    step();
    step();
    held = q[0];
    check1("bp_loaded", bus.sink_valid, 1'b1);
    bus.sink_full = 1'b1;
    bus.src0_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_hold", bus.sink_data, held);
      check1("bp_valid", bus.sink_valid, 1'b1);
      check1("bp_ready0", bus.src0_ready, 1'b0);
      check1("bp_ready1", bus.src1_ready, 1'b0);
      check("bp_timeouts", 48'(bus.timeout_count), 48'd0);
    end
    bus.sink_full = 1'b0;
    bus.src0_valid = 1'b1;
    repeat (4) step();
    check1("bp_resume", x0, 1'b1);
    check("bp_no_timeout", 48'(bus.timeout_count), 48'd0);
    drain();
    // timeout: src0 sends two samples then goes quiet; src1 waits
    bus.src_enable = 2'b01;
    bus.src0_valid = 1'b1;
    bus.src1_valid = 1'b1;
    repeat (3) step();
    bus.src0_valid = 1'b0;
    bus.src_enable = 2'b11;
    for (int n = 1; n <= 16; n++) begin
      step();
      check1("to_src1_wait", x1, 1'b0);
      check1("to_active", bus.active_src, n == 16);
      check("to_count", 48'(bus.timeout_count), 48'(n == 16));
    end
    step();
    check1("to_src1_go", x1, 1'b1);
    // disable mid src0 burst
    bus.src0_valid = 1'b1;
    for (int n = 0; n < 10 && bus.active_src != 1'b0; n++) step();
    check1("dis_reached_g0", bus.active_src, 1'b0);
    step();
    check1("dis_src0_sent", x0, 1'b1);
    bus.src_enable = 2'b10;
    #1;
    check1("dis_ready0_now", bus.src0_ready, 1'b0);
    check1("dis_still_granted", bus.grant_valid, 1'b1);
    step();
    check1("dis_no_src0", x0, 1'b0);
    check1("dis_active1", bus.active_src, 1'b1);
    check("dis_delivered", 48'(q.size()), 48'd0);
    step();
    check1("dis_src1_go", x1, 1'b1);
    // reset mid-burst drops the pending sample at once
    check1("rst_mid_loaded", bus.sink_valid, 1'b1);
    reset = 1'b1;
    #1;
    check1("rst_mid_valid", bus.sink_valid, 1'b0);
    check("rst_mid_data", bus.sink_data, 48'd0);
    check1("rst_mid_ready1", bus.src1_ready, 1'b0);
    check1("rst_mid_grant", bus.grant_valid, 1'b0);
    check("rst_mid_timeouts", 48'(bus.timeout_count), 48'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/audio_src_arbiter.md
# audio_src_arbiter

Round-robin arbiter that shares the single stereo sample sink of `adau_interface` between two audio sources, e.g. `sine_generator` and a CPU-fed sample FIFO. Grants are held for bursts of `BURST_LEN` samples, released early on source timeout or disable, and samples pass through a one-entry output register. The block sits between the sources and `adau_interface.audio_in`/`audio_in_valid`/`audio_full` in the SoC clock domain.

## Interface
- `WIDTH`, 24: bits per channel; a sample is `2*WIDTH` bits, left channel in the upper half.
- `BURST_LEN`, 64: samples per grant; legal range 1..65535.
- `IDLE_TIMEOUT`, 16: consecutive cycles the granted source may hold `valid` low before the grant is released; legal range 1..65535.
- `clk` in 1: SoC clock, 120 MHz.
- `reset` in 1: asynchronous, active-high.
- `src_enable` in 2: per-source enable; bit i gates source i.
- `src0_data` in 2*WIDTH, `src0_valid` in 1, `src0_ready` out 1: source 0 handshake.
- `src1_data` in 2*WIDTH, `src1_valid` in 1, `src1_ready` out 1: source 1 handshake.
- `sink_data` out 2*WIDTH, `sink_valid` out 1: output register contents and valid flag; connect to `audio_in` and `audio_in_valid`.
- `sink_full` in 1: sink back-pressure; connect to `audio_full`.
- `grant_valid` out 1: high in GRANT0 or GRANT1.
- `active_src` out 1: index of the granted source; holds its last value while in IDLE.
- `burst_done` out 1: one-cycle pulse when a grant ends after `BURST_LEN` samples.
- `timeout_count` out 16: saturating count of grants released by timeout.

## Operation
- FSM states are IDLE, GRANT0 and GRANT1. Reset enters IDLE with `active_src`=0 and `last`=1.
- IDLE: if any `src_enable` bit is set, move to GRANT of the enabled source, preferring `!last` when both are enabled. Clear `burst_cnt` and `idle_cnt`.
- GRANTi accept: `srci_ready = (state==GRANTi) && src_enable[i] && (!sink_valid || !sink_full)`. Neither ready is asserted outside its GRANT state.
- A source transfer occurs when `srci_valid && srci_ready`. On a transfer, the output register loads `srci_data`, `sink_valid` is set, `burst_cnt` increments and `idle_cnt` clears.
- A sink transfer occurs when `sink_valid && !sink_full`. It clears `sink_valid` unless a source transfer happens in the same cycle. A simultaneous sink and source transfer replaces the register contents, and `sink_valid` stays 1.
- Grant ends, and `last` is set to i, on any of the following:
  - **Burst complete:** the transfer with `burst_cnt`==`BURST_LEN`-1. `burst_done` pulses.
  - **Timeout:** `idle_cnt` reaches `IDLE_TIMEOUT`. `idle_cnt` counts cycles with `srci_valid` low, and `timeout_count` increments unless it is at 0xFFFF.
  - **Disable:** `src_enable[i]` is low.
- On grant end the next state is GRANT of the other source if that source is enabled, else GRANTi if `src_enable[i]` is still high, else IDLE.
- A sample already in the output register is always delivered; the grant change never drops it.
- Back-pressure freezes `idle_cnt`: cycles with `sink_valid && sink_full` do not count toward timeout.

## Timing
- Reset values: `sink_data`=0, `sink_valid`=0, `src0_ready`=`src1_ready`=0, `grant_valid`=0, `active_src`=0, `burst_done`=0, `timeout_count`=0.
- Latency: the sample is on `sink_data` with `sink_valid`=1 one cycle after its source transfer.
- Throughput: one sample per cycle while the sink is not full.
- IDLE→GRANT takes one cycle, so ready rises in the second cycle after enable is seen.
- GRANTi→GRANTj is direct, so the new source's ready can be high the cycle after the last transfer. The old source's ready is low in that cycle.
- `burst_done` is asserted in the cycle after the final transfer, registered.
- `src_enable` falling mid-burst deasserts that source's ready in the same cycle (combinational gate). The FSM leaves GRANTi in the next cycle, and `burst_cnt` is discarded.
- Reset mid-burst empties the output register immediately; the sample is lost.

## Configuration
- `AUDIO_ARB_SILENCE_FILL_EN` defined: in IDLE, the output register loads all-zero samples whenever `!sink_valid || !sink_full`. The DAC therefore keeps receiving silence when no source is enabled, and the first zero appears one cycle after entering IDLE.
- Not defined: in IDLE, `sink_valid` falls after the pending sample drains and stays low.

## Test plan
- **Single source.** Stimulus: `src_enable`=01, src0 always valid with an incrementing pattern, `sink_full`=0, `BURST_LEN`=4. Required: `sink_data` sequence 0,1,2,3,4,… with no gaps, and `burst_done` every 4 samples while `active_src` stays 0.
- **Round-robin.** Stimulus: `src_enable`=11, both sources always valid, `BURST_LEN`=4. Required: sink shows 4 src0 samples, then 4 src1, alternating, with zero bubble cycles.
- **Back-pressure.** Stimulus: `sink_full` held high for 10 cycles with one sample held. Required: the held sample stays stable, both readys are 0, `idle_cnt` is frozen, and nothing is lost after release.
- **Timeout.** Stimulus: `IDLE_TIMEOUT`=16, src0 `valid` low after 2 samples, src1 valid. Required: grant moves to src1 exactly 16 cycles after the last src0 sample, and `timeout_count`=1.
- **Disable mid-burst.** Stimulus: `src_enable` 11→10 during a src0 burst. Required: `src0_ready` is 0 in the same cycle, the pending sample is still delivered, and the next state is GRANT1.
- **Silence fill.** Stimulus: `src_enable`=00, with and without `AUDIO_ARB_SILENCE_FILL_EN`. Required with the macro: `sink_valid`=1 and `sink_data`=0 continuously. Required without: `sink_valid`=0.
